execute_stage: RTL

//  16-bit execute stage sitting directly upstream of the memory stage; owns the EX/MEM pipeline register.

---
 rtl/execute_stage_pkg.sv | 36 +++
 rtl/iter_muldiv.sv | 84 ++++++++
 rtl/execute_stage.sv | 113 +++++++++++
 3 files changed

// File: rtl/execute_stage_pkg.sv
// Shared definitions for the execute stage: datapath width, ALU op codes and
// the iterative multiply/divide FSM states.
package execute_stage_pkg;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned ITER  = 16;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_NOR  = 4'd5,
    ALU_SLT  = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9,
    ALU_MUL  = 4'd10,
    ALU_DIVU = 4'd11
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1
  } state_t;

  typedef struct packed {
    logic mem_write;
    logic mem_read;
    logic branch;
    logic reg_write;
    logic mem_to_reg;
  } ctrl_t;

endpackage

// File: rtl/iter_muldiv.sv
// Iterative 16-step unsigned multiplier (shift-add) and restoring divider.
// result is the value of the final step, valid while done is high.
module iter_muldiv
  import execute_stage_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  state_t           state, state_nx;
  logic [3:0]       cnt;
  logic             div_q;
  logic [WIDTH-1:0] x_q, y_q, b_q;
  logic [WIDTH-1:0] x_nx, y_nx;
  logic [WIDTH:0]   rem_sh;

  // x holds the accumulator (MUL) or remainder (DIVU); y the multiplicand or
  // the dividend bits shifting into the quotient; b the multiplier or divisor.
  always_comb begin
    x_nx   = x_q;
    y_nx   = {y_q[WIDTH-2:0], 1'b0};
    rem_sh = {x_q, y_q[WIDTH-1]};
    if (div_q) begin
      if (rem_sh >= {1'b0, b_q}) begin
        x_nx = WIDTH'(rem_sh - {1'b0, b_q});
        y_nx = {y_q[WIDTH-2:0], 1'b1};
      end else begin
        x_nx = rem_sh[WIDTH-1:0];
      end
    end else if (b_q[0]) begin
      x_nx = x_q + y_q;
    end
  end

  assign result = div_q ? y_nx : x_nx;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = ST_IDLE;
    case (state)
      ST_IDLE: state_nx = start ? ST_RUN : ST_IDLE;
      ST_RUN:  state_nx = (cnt == 4'(ITER - 1)) ? ST_IDLE : ST_RUN;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == ST_RUN);
    done = (state == ST_RUN) && (cnt == 4'(ITER - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      div_q <= 1'b0;
      x_q   <= '0;
      y_q   <= '0;
      b_q   <= '0;
    end else if (state == ST_IDLE && start) begin
      cnt   <= '0;
      div_q <= op_div;
      x_q   <= '0;
      y_q   <= a;
      b_q   <= b;
    end else if (state == ST_RUN) begin
      cnt <= cnt + 4'd1;
      x_q <= x_nx;
      y_q <= y_nx;
      if (!div_q) b_q <= b_q >> 1;
    end
  end

endmodule

// File: rtl/execute_stage.sv
// 16-bit execute stage: single-cycle ALU, iterative MUL/DIVU, and the EX/MEM
// pipeline register feeding the memory stage.
module execute_stage
  import execute_stage_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic [WIDTH-1:0] imm,
  input  logic             ALUSrc,
  input  logic             MemWrite_in,
  input  logic             MemRead_in,
  input  logic             Branch_in,
  input  logic             RegWrite_in,
  input  logic             MemtoReg_in,
  input  logic [2:0]       write_reg_in,
  output logic             busy,
  output logic             out_valid,
  output logic [WIDTH-1:0] alu_result,
  output logic [WIDTH-1:0] write_data,
  output logic             Zero,
  output logic             MemWrite,
  output logic             MemRead,
  output logic             Branch,
  output logic             RegWrite,
  output logic             MemtoReg,
  output logic [2:0]       write_reg
);

  logic [WIDTH-1:0] op_b, alu_y, md_result, pend_wd;
  logic             accept, is_multi, md_busy, md_done;
  ctrl_t            ctrl_in, pend_ctrl;
  logic [2:0]       pend_reg;

  assign op_b     = ALUSrc ? imm : src_b;
  assign is_multi = (alu_op == ALU_MUL) || (alu_op == ALU_DIVU);
  assign accept   = in_valid && !md_busy;
  assign busy     = md_busy;
  assign ctrl_in  = {MemWrite_in, MemRead_in, Branch_in, RegWrite_in, MemtoReg_in};

  always_comb begin
    alu_y = op_b;
    case (alu_op_t'(alu_op))
      ALU_ADD: alu_y = src_a + op_b;
      ALU_SUB: alu_y = src_a - op_b;
      ALU_AND: alu_y = src_a & op_b;
      ALU_OR:  alu_y = src_a | op_b;
      ALU_XOR: alu_y = src_a ^ op_b;
      ALU_NOR: alu_y = ~(src_a | op_b);
      ALU_SLT: alu_y = {{(WIDTH-1){1'b0}}, $signed(src_a) < $signed(op_b)};
      ALU_SLL: alu_y = src_a << op_b[3:0];
      ALU_SRL: alu_y = src_a >> op_b[3:0];
      ALU_SRA: alu_y = WIDTH'($signed(src_a) >>> op_b[3:0]);
      default: alu_y = op_b;
    endcase
  end

  iter_muldiv u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .start  (accept && is_multi),
    .op_div (alu_op == ALU_DIVU),
    .a      (src_a),
    .b      (op_b),
    .busy   (md_busy),
    .done   (md_done),
    .result (md_result)
  );

  // Store data and control of a MUL/DIVU are parked here until the result
  // emerges; the output register meanwhile behaves as a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      alu_result <= '0;
      write_data <= '0;
      Zero       <= 1'b0;
      {MemWrite, MemRead, Branch, RegWrite, MemtoReg} <= '0;
      write_reg  <= '0;
      pend_ctrl  <= '0;
      pend_wd    <= '0;
      pend_reg   <= '0;
    end else if (md_done) begin
      out_valid  <= 1'b1;
      alu_result <= md_result;
      Zero       <= (md_result == '0);
      write_data <= pend_wd;
      write_reg  <= pend_reg;
      {MemWrite, MemRead, Branch, RegWrite, MemtoReg} <= pend_ctrl;
    end else if (accept && !is_multi) begin
      out_valid  <= 1'b1;
      alu_result <= alu_y;
      Zero       <= (alu_y == '0);
      write_data <= src_b;
      write_reg  <= write_reg_in;
      {MemWrite, MemRead, Branch, RegWrite, MemtoReg} <= ctrl_in;
    end else begin
      out_valid <= 1'b0;
      if (!md_busy) begin
        {MemWrite, MemRead, Branch, RegWrite} <= '0;
      end
      if (accept) begin
        pend_ctrl <= ctrl_in;
        pend_wd   <= src_b;
        pend_reg  <= write_reg_in;
      end
    end
  end

endmodule
